// File: rtl/bb_pkg.sv
// bb_pkg: shared FSM states, UART frame geometry and field helpers for the bus bridge slave.
package bb_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, SEND, TXWAIT, RXWAIT, RDATA} bb_state_t;
  localparam int UART_TX_DATA_WIDTH = 32;
  localparam int UART_RX_DATA_WIDTH = 16;
  function automatic int data_ofs(int aw);
    return aw;
  endfunction
  function automatic int mode_bit(int aw, int dw);
    return aw + dw;
  endfunction
endpackage

// File: rtl/uart_mav.sv
// uart_mav: 8N1-style UART (start, LSB-first data, stop) with independent TX/RX frame widths.
// Ports: clk, rstn (sync active-low), data_input/data_en start a TX frame when tx_busy=0,
// tx line out; rx line in, data_output holds last good RX frame, ready rises when it lands
// and falls at the next start bit.
module uart_mav #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int TX_DATA_WIDTH = 32,
  parameter int RX_DATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [TX_DATA_WIDTH-1:0] data_input,
  input  logic                     data_en,
  output logic [RX_DATA_WIDTH-1:0] data_output,
  output logic                     ready,
  output logic                     tx_busy,
  output logic                     tx,
  input  logic                     rx
);
  localparam int KW = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int TBW = $clog2(TX_DATA_WIDTH + 3);
  localparam int RBW = $clog2(RX_DATA_WIDTH + 3);
  logic [TX_DATA_WIDTH+1:0] tx_sr;
  logic [KW-1:0] tx_clk, rx_clk;
  logic [TBW-1:0] tx_left;
  logic [1:0] rx_sync;
  logic rx_busy;
  logic [RBW-1:0] rx_bit;
  logic [RX_DATA_WIDTH-1:0] rx_sr;
  logic rx_s;
  assign tx = ~tx_busy | tx_sr[0];
  assign rx_s = rx_sync[1];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_sr <= '0;
      tx_clk <= '0;
      tx_left <= '0;
      tx_busy <= 1'b0;
    end else if (!tx_busy) begin
      if (data_en) begin
        tx_sr <= {1'b1, data_input, 1'b0};
        tx_clk <= '0;
        tx_left <= TBW'(TX_DATA_WIDTH + 2);
        tx_busy <= 1'b1;
      end
    end else if (tx_clk == KW'(CLOCKS_PER_PULSE - 1)) begin
      tx_clk <= '0;
      tx_sr <= {1'b1, tx_sr[TX_DATA_WIDTH+1:1]};
      tx_left <= tx_left - 1'b1;
      tx_busy <= tx_left != TBW'(1);
    end else begin
      tx_clk <= tx_clk + 1'b1;
    end
  end
  // Start bit is checked at mid-bit, then every later bit is sampled one full period apart.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_sync <= 2'b11;
      rx_busy <= 1'b0;
      rx_clk <= '0;
      rx_bit <= '0;
      rx_sr <= '0;
      data_output <= '0;
      ready <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy <= 1'b1;
          rx_clk <= '0;
          rx_bit <= '0;
          ready <= 1'b0;
        end
      end else if (rx_clk == (rx_bit == '0 ? KW'(CLOCKS_PER_PULSE / 2 - 1) : KW'(CLOCKS_PER_PULSE - 1))) begin
        rx_clk <= '0;
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == '0) rx_busy <= ~rx_s;
        else if (rx_bit <= RBW'(RX_DATA_WIDTH)) rx_sr <= {rx_s, rx_sr[RX_DATA_WIDTH-1:1]};
        else begin
          rx_busy <= 1'b0;
          if (rx_s) begin
            ready <= 1'b1;
            data_output <= rx_sr;
          end
        end
      end else begin
        rx_clk <= rx_clk + 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_bridge_slave.sv
// bus_bridge_slave: serial-bus slave that forwards transactions over UART as {mode,data,addr} frames.
// Ports: clk, rstn (sync active-low); swdata/smode/mvalid serial master input (LSB first);
// srdata/svalid serial read data out; sready idle; ssplit split request; u_tx/u_rx UART lines.
// Optional: define BB_SLAVE_SPLIT_EN to raise ssplit while a read waits for its UART reply.
module bus_bridge_slave
  import bb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int UART_CLOCKS_PER_PULSE = 5208
) (
  input  logic clk,
  input  logic rstn,
  input  logic swdata,
  input  logic smode,
  input  logic mvalid,
  output logic srdata,
  output logic svalid,
  output logic sready,
  output logic ssplit,
  output logic u_tx,
  input  logic u_rx
);
  localparam int CW = $clog2(SLAVE_MEM_ADDR_WIDTH + DATA_WIDTH + 1);
  bb_state_t state, state_n;
  logic [SLAVE_MEM_ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] data_sr, rd_sr;
  logic [CW-1:0] cnt;
  logic mode_q, ready_q, tx_seen, rise, last_addr, last_data;
  logic u_en, u_tx_busy, u_ready;
  logic [UART_TX_DATA_WIDTH-1:0] u_din;
  logic [UART_RX_DATA_WIDTH-1:0] u_dout;
  logic rx_unused;
  assign rise = u_ready & ~ready_q;
  assign last_addr = cnt == CW'(SLAVE_MEM_ADDR_WIDTH - 1);
  assign last_data = cnt == CW'(DATA_WIDTH - 1);
  assign srdata = svalid & rd_sr[0];
  assign rx_unused = ^u_dout[UART_RX_DATA_WIDTH-1:DATA_WIDTH];
  always_comb begin
    u_din = '0;
    u_din[ADDR_WIDTH-1:0] = ADDR_WIDTH'(addr_sr);
    u_din[data_ofs(ADDR_WIDTH)+:DATA_WIDTH] = mode_q ? data_sr : '0;
    u_din[mode_bit(ADDR_WIDTH, DATA_WIDTH)] = mode_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    u_en = 1'b0;
    sready = 1'b0;
    svalid = 1'b0;
    case (state)
      IDLE: begin
        sready = 1'b1;
        if (mvalid) state_n = ADDR;
      end
      ADDR: if (mvalid && last_addr) state_n = mode_q ? WDATA : SEND;
      WDATA: if (mvalid && last_data) state_n = SEND;
      SEND: if (!u_tx_busy) begin
        u_en = 1'b1;
        state_n = TXWAIT;
      end
      TXWAIT: if (tx_seen && !u_tx_busy) state_n = mode_q ? IDLE : RXWAIT;
      RXWAIT: if (rise) state_n = RDATA;
      RDATA: begin
        svalid = 1'b1;
        if (last_data) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // tx_seen is set from the second TXWAIT cycle, so busy is never judged right after u_en.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_sr <= '0;
      data_sr <= '0;
      rd_sr <= '0;
      cnt <= '0;
      mode_q <= 1'b0;
      ready_q <= 1'b0;
      tx_seen <= 1'b0;
    end else begin
      ready_q <= u_ready;
      tx_seen <= state == TXWAIT;
      case (state)
        IDLE: if (mvalid) begin
          addr_sr <= {swdata, addr_sr[SLAVE_MEM_ADDR_WIDTH-1:1]};
          mode_q <= smode;
          cnt <= CW'(1);
        end
        ADDR: if (mvalid) begin
          addr_sr <= {swdata, addr_sr[SLAVE_MEM_ADDR_WIDTH-1:1]};
          cnt <= last_addr ? '0 : cnt + 1'b1;
        end
        WDATA: if (mvalid) begin
          data_sr <= {swdata, data_sr[DATA_WIDTH-1:1]};
          cnt <= last_data ? '0 : cnt + 1'b1;
        end
        RXWAIT: if (rise) rd_sr <= u_dout[DATA_WIDTH-1:0];
        RDATA: begin
          rd_sr <= rd_sr >> 1;
          cnt <= last_data ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
`ifdef BB_SLAVE_SPLIT_EN
  assign ssplit = (state == TXWAIT && !mode_q) || (state == RXWAIT && !rise);
`else
  assign ssplit = 1'b0;
`endif
  uart_mav #(
    .CLOCKS_PER_PULSE(UART_CLOCKS_PER_PULSE),
    .TX_DATA_WIDTH(UART_TX_DATA_WIDTH),
    .RX_DATA_WIDTH(UART_RX_DATA_WIDTH)
  ) u_uart (
    .clk(clk),
    .rstn(rstn),
    .data_input(u_din),
    .data_en(u_en),
    .data_output(u_dout),
    .ready(u_ready),
    .tx_busy(u_tx_busy),
    .tx(u_tx),
    .rx(u_rx)
  );
endmodule

// File: doc/bus_bridge_slave.md
# bus_bridge_slave

Remote-facing slave end of the UART bus bridge. The block sits on the serial system bus as a slave and deserialises incoming master transactions (address, mode, write data). Each transaction is packed into a 32-bit `{mode, data, addr}` UART frame and transmitted to the remote board, where a `bus_bridge_master` replays it. For reads, the block waits for the 16-bit UART reply and shifts the read data back onto the serial bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: width of the bus address field in the UART frame.
- `DATA_WIDTH`, 8: bus data width.
- `SLAVE_MEM_ADDR_WIDTH`, 12: local address bits received serially from the bus.
- `UART_CLOCKS_PER_PULSE`, 5208: clocks per UART bit, passed to `uart_mav`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `swdata`  in  1  serial write data and address from the master, LSB first.
- `smode`  in  1  0 = read, 1 = write; sampled on the first address bit.
- `mvalid`  in  1  `swdata` bit valid.
- `srdata`  out  1  serial read data, LSB first.
- `svalid`  out  1  `srdata` bit valid.
- `sready`  out  1  slave idle and able to accept a transaction.
- `ssplit`  out  1  split request to the arbiter (see Configuration).
- `u_tx`  out  1  UART transmit line.
- `u_rx`  in  1  UART receive line.

## Operation
- FSM states are IDLE, ADDR, WDATA, SEND, TXWAIT, RXWAIT and RDATA.
- IDLE: `sready`=1. The first cycle with `mvalid`=1 captures `swdata` as address bit 0 and latches `smode`, then the FSM goes to ADDR.
- ADDR: one address bit is shifted per `mvalid` cycle. Cycles with `mvalid`=0 are stalls and shift nothing. After `SLAVE_MEM_ADDR_WIDTH` bits:
  - write (`smode`=1): go to WDATA;
  - read: go to SEND.
- WDATA: `DATA_WIDTH` bits are shifted the same way, then the FSM goes to SEND.
- Frame layout:
  - bits [ADDR_WIDTH-1:0] = address, zero-extended;
  - bits [ADDR_WIDTH+:DATA_WIDTH] = write data, or 0 for a read;
  - bit [ADDR_WIDTH+DATA_WIDTH] = mode;
  - remaining upper bits = 0.
- SEND: when `u_tx_busy`=0, pulse `u_en` for exactly one cycle with the frame on `u_din`, then go to TXWAIT.
- TXWAIT: exit once `u_tx_busy` is sampled 0, no earlier than 2 cycles after the `u_en` pulse.
  - write: go to IDLE;
  - read: go to RXWAIT.
- RXWAIT: wait for a rising edge of the UART `ready` output. Capture `data_output[DATA_WIDTH-1:0]` into the read shift register and go to RDATA. Upper reply bits are ignored.
- RDATA: hold `svalid`=1 for `DATA_WIDTH` consecutive cycles while presenting read data LSB first on `srdata`, then go to IDLE.
- A UART `ready` rising edge seen in any state other than RXWAIT is discarded.
- `sready`=0 in every state except IDLE.

## Timing
- Reset values of all outputs: `srdata`=0, `svalid`=0, `sready`=1, `ssplit`=0, `u_tx`=idle high. Internal: `u_en`=0, FSM in IDLE, shift registers cleared.
- `sready` falls in the cycle after the first `mvalid` bit is accepted.
- Write: the `u_en` pulse occurs 1 cycle after the last data bit is shifted, provided the transmitter is idle.
- Read: the first `svalid` cycle occurs 1 cycle after the UART `ready` rising edge is detected. Edge detection uses a registered previous-value of `ready`.
- Reset asserted mid-operation: the FSM returns to IDLE on the next edge and the partial frame is abandoned. `uart_mav` is reset by the same `rstn`.
- Bits arriving with `mvalid`=1 while in SEND, TXWAIT, RXWAIT or RDATA are ignored. Masters must observe `sready`.

## Configuration
- Macro `BB_SLAVE_SPLIT_EN`.
- Defined:
  - `ssplit` rises on entry to TXWAIT for a read and stays high through RXWAIT, so the arbiter can grant the bus to others;
  - `ssplit` drops in the cycle the reply is captured, one cycle before RDATA starts.
- Undefined: `ssplit` is tied 0 and the read holds the bus until RDATA completes.

## Structure
- Shared package `bb_pkg` holds:
  - the FSM state enum;
  - frame field offsets (mode bit index, data offset);
  - `UART_TX_DATA_WIDTH`=32 and `UART_RX_DATA_WIDTH`=16 for this end, which are the mirror of the master bridge.
- One sub-module: the existing `uart_mav`, configured TX=32 and RX=16. Deserialisation and serialisation are inline.

## Test plan
- Write, address 0x0A5, data 0x3C -> UART frame 0x013C00A5 transmitted; `sready` returns to 1 after TXWAIT; `svalid` never asserts.
- Read, address 0x123; remote replies 0x0077 -> frame 0x00000123; `srdata` carries 1,1,1,0,1,1,1,0 over 8 consecutive `svalid` cycles.
- Read with `BB_SLAVE_SPLIT_EN` defined -> `ssplit` is high from TXWAIT until the reply edge, and low during RDATA. Without the macro, `ssplit` stays 0 throughout.
- Address bits with `mvalid` gaps of 3 idle cycles -> same frame as the gap-free case.
- Reset pulsed during RXWAIT, then a late reply 0x00AA arrives -> FSM is in IDLE, reply is discarded, no `svalid`.
- Back-to-back writes 0x001/0x11 then 0x002/0x22 -> two frames 0x01110001 and 0x01220002, in order, with the second `u_en` only after `u_tx_busy` is low.
